// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for a shared single-port data memory.
// Each grant runs IDLE -> ACCESS -> RESP, so one access completes every three cycles.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prio_mode,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Handshake: reqN is a level held (with weN/addrN/wdataN stable) until the
  // one-cycle ackN pulse; a req still high in the following IDLE is a new request.
  logic [1:0] state;
  logic       gnt;
  logic       last_gnt;
  logic       lat_we;
  logic       winner;

  // Round-robin contention hands the grant to the port that did not win last time.
  always_comb begin
    winner = ~req0;
    if (!prio_mode && req0 && req1) winner = ~last_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= ACCESS;
            gnt       <= winner;
            last_gnt  <= winner;
            lat_we    <= winner ? we1 : we0;
            mem_addr  <= winner ? addr1 : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (!lat_we) begin
            if (gnt) rdata1 <= mem_rdata;
            else     rdata0 <= mem_rdata;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and acks decode straight from state so reset removes them at once.
  assign mem_read  = (state == ACCESS) && !lat_we;
  assign mem_write = (state == ACCESS) && lat_we;
  assign ack0      = (state == RESP) && !gnt;
  assign ack1      = (state == RESP) && gnt;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared 256 x 8 data memory. It accepts independent read/write requests from the CPU instruction-fetch path (port 0) and the load/store path (port 1). It grants the single memory port to one requester at a time and drives the memory's `memread`, `memwrite`, `address` and `writedata` inputs. It registers `readdata` and returns it to the granted requester with a one-cycle acknowledge pulse.

## Interface
Parameters:
- `AW`, 8, address width (memory depth 2^AW).
- `DW`, 8, data width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `prio_mode`  in  1  0 = round-robin, 1 = fixed priority (port 0 wins). Sampled in IDLE only.
- `req0`, `req1`  in  1  request, level; held until matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req high.
- `addr0`, `addr1`  in  AW  request address; stable while req high.
- `wdata0`, `wdata1`  in  DW  write data; stable while req high.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DW  read result; valid when ack is high for a read; held until that port's next read completes.
- `mem_read`  out  1  to memory `memread`.
- `mem_write`  out  1  to memory `memwrite`.
- `mem_addr`  out  AW  to memory `address`.
- `mem_wdata`  out  DW  to memory `writedata`.
- `mem_rdata`  in  DW  from memory `readdata` (combinational read).
- `busy`  out  1  high in ACCESS and RESP.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req high: choose a winner, latch `gnt` (0/1) plus that port's we/addr/wdata, go to ACCESS.
- Winner selection:
  - `prio_mode=1`: port 0 if `req0`, else port 1.
  - `prio_mode=0`, single req: that port wins.
  - `prio_mode=0`, both req: the port opposite to `last_gnt` wins.
- `last_gnt` updates on every grant.
- ACCESS (exactly one cycle):
  - Drive `mem_addr` and `mem_wdata` from the latched values.
  - Assert `mem_write` if write, otherwise `mem_read`.
  - Read: capture `mem_rdata` into `rdata[gnt]` at the ACCESS→RESP edge.
  - Write: memory commits at that same edge.
  - Go to RESP.
- RESP (one cycle):
  - Assert `ack[gnt]`; all memory strobes low.
  - Always go to IDLE.
  - Requester must drop req on the edge ending RESP. A req still high in the next IDLE is treated as a new request.
- Only one of `mem_read`/`mem_write` is ever high, and only in ACCESS. Outside ACCESS both are low, and `mem_addr`/`mem_wdata` hold their last values.
- A request arriving while busy waits; it is never dropped.

## Timing
- Reset values:
  - state IDLE; `ack0`, `ack1` = 0; `mem_read`, `mem_write` = 0.
  - `mem_addr`, `mem_wdata` = 0; `rdata0`, `rdata1` = 0; `busy` = 0.
  - `last_gnt` = 1, so port 0 wins the first contended round-robin cycle.
- Latency: req sampled high at edge N (IDLE) → ACCESS during cycle N+1 → ack high during cycle N+2. Minimum req-to-ack = 2 cycles.
- Throughput: one access per 3 cycles. Back-to-back contended requests alternate 0,1,0,1 in round-robin.
- A req deasserted before grant is lost silently; this is a protocol violation with no error flag.
- Reset asserted mid-ACCESS:
  - Strobes drop immediately (asynchronous); the access is abandoned and no ack is issued.
  - A write may or may not have committed.
  - `rdata` returns to 0.
- Reset asserted mid-RESP: the ack pulse is truncated to 0.
- Release of reset is synchronous to `clk` at the next rising edge.
- Address wrap: none inside the arbiter. Addresses pass through unmodified; 0xFF is valid.

## Test plan
- Reset: hold `rst=0`, toggle `req0=1` → all outputs 0, no strobes. Release → first grant to port 0, ack0 two cycles after release-edge sample.
- Single write/read:
  - Port 1 writes 0xA5 to 0x3C; ack1 at +2 cycles with `mem_write` high only in the ACCESS cycle.
  - Port 0 then reads 0x3C → `rdata0`=0xA5 with ack0.
- Round-robin contention: `req0`, `req1` both high continuously with reads of 0x10 and 0x20 → grant order 0,1,0,1, acks every 3 cycles alternating, `rdata0`=mem[0x10], `rdata1`=mem[0x20].
- Fixed priority: `prio_mode=1`, both req held for 4 accesses → port 0 acked 4 times, ack1 never. Set `prio_mode=0` → port 1 served next.
- Reset mid-operation: assert `rst=0` in the ACCESS cycle of a read → no ack, `rdata`=0, `busy`=0. Re-issue after release → completes normally.
- Boundary address: write 0xFF to 0xFF and 0x00 to 0x00 from alternating ports → both read back correctly; `mem_read` and `mem_write` are never both high in any cycle.
